// File: rtl/uart_pkg.sv
// Shared UART types, line levels and parity helper for the serial path.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Widest word parity_bit accepts; callers zero-extend narrower words.
  localparam int unsigned UART_MAX_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic logic parity_bit(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter with synchronous clear; tick marks the last cycle of a bit period.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick_c
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // pre_tick_c lets callers register strobes that must coincide with tick.
  assign tick       = (cnt_q == LAST);
  assign pre_tick_c = (cnt_q == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the upstream FIFO one word per frame.
// Optional parity bit compiled in with UART_TX_PARITY_EN (adds PARITY_ODD).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_DATA_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP_IDX = IW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam tx_state_t AFTER_DATA = ST_STOP;
`endif

  tx_state_t             state_q, state_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  baud_clear_c;
  logic                  bit_tick_c;
  logic                  pre_tick_c;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (baud_clear_c),
    .tick      (bit_tick_c),
    .pre_tick_c(pre_tick_c)
  );

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_bit(UART_MAX_DATA_WIDTH'(fifo_data), PARITY_ODD);
`endif
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_tick_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick_c) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA_IDX) begin
            state_d   = AFTER_DATA;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick_c) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick_c) begin
          if (bit_idx_q == LAST_STOP_IDX) begin
            bit_idx_d = '0;
            state_d   = (tx_en && !fifo_empty) ? ST_FETCH : ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    baud_clear_c = (state_d != state_q);
    rd_en_d      = (state_d == ST_FETCH);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_STOP) && (bit_idx_q == LAST_STOP_IDX) && pre_tick_c;

    case (state_d)
      ST_START: tx_d = UART_START_LEVEL;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= UART_IDLE_LEVEL;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: queue-backed FIFO, frame-timeline reference model.
module tb_fifo_uart_tx;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int SB   = 1;
  localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = 1 + DW + P + SB;
  localparam int TOT = 2 + NB * CPB;

  logic          clk;
  logic          rst;
  logic          tx_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD  (PODD)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] q[$];
  bit            m_act = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_word = '0;
  int            cyc = 0;
  int            n_rd = 0;
  int            n_done = 0;
  int            first_rd_cyc = -1;
  int            first_fall_cyc = -1;
  int            done_cyc = -1;
  bit            gap_on = 1'b0;
  int            gap_cnt = 0;
  int            last_gap = -1;
  logic          bitlog[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Line level at offset t from the fetch cycle: two high cycles, then start/data/parity/stop.
  function automatic logic model_tx(input int t, input logic [DW-1:0] w);
    int b;
    if (t < 2) return 1'b1;
    b = (t - 2) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (P == 1 && b == DW + 1) return (^w) ^ PODD;
    return 1'b1;
  endfunction

  task automatic push(input logic [DW-1:0] d);
    q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_stats();
    n_rd = 0;
    n_done = 0;
    first_rd_cyc = -1;
    first_fall_cyc = -1;
    done_cyc = -1;
    last_gap = -1;
    gap_on = 1'b0;
    bitlog.delete();
  endtask

  // One clock: FIFO behaviour, model advance, and comparison of all outputs.
  task automatic cycle();
    logic          p_rst, p_en, p_empty, p_rd;
    logic [DW-1:0] p_front;
    logic          e_tx;
    p_rst   = rst;
    p_en    = tx_en;
    p_empty = fifo_empty;
    p_rd    = fifo_rd_en;
    p_front = (q.size() > 0) ? q[0] : '0;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rd === 1'b1 && q.size() > 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);

    if (p_rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (p_en && !p_empty) begin
        m_act = 1'b1;
        m_t = 0;
        m_word = p_front;
      end
    end else if (m_t == TOT - 1) begin
      if (p_en && !p_empty) begin
        m_t = 0;
        m_word = p_front;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_t++;
    end

    e_tx = m_act ? model_tx(m_t, m_word) : 1'b1;
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(m_act));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(m_act && m_t == 0));
    check("frame_done", 32'(frame_done), 32'(m_act && m_t == TOT - 1));

    if (fifo_rd_en === 1'b1) begin
      n_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (tx === 1'b0 && first_fall_cyc < 0) first_fall_cyc = cyc;
    if (m_act && m_t >= 2 && ((m_t - 2) % CPB) == CPB / 2) bitlog.push_back(tx);
    if (frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      gap_on = 1'b1;
      gap_cnt = 0;
    end else if (gap_on) begin
      if (tx === 1'b0) begin
        last_gap = gap_cnt;
        gap_on = 1'b0;
      end else if (busy !== 1'b1) begin
        gap_on = 1'b0;
      end else begin
        gap_cnt++;
      end
    end
  endtask

  task automatic run_until_idle(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (!m_act && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_offset(input int target, input int max);
    bit hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (m_act && m_t == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("offset_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] packed_bits();
    logic [15:0] g = '0;
    for (int i = 0; i < bitlog.size() && i < 16; i++) g[i] = bitlog[i];
    return g;
  endfunction

  initial begin
    int c0;
    rst = 1'b1;
    tx_en = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;

    // Reset state
    cycle();
    cycle();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    cycle();

    // Single 0xA5 frame: latency, bit pattern, single pop and frame_done
    clear_stats();
    push(8'hA5);
    tx_en = 1'b1;
    c0 = cyc;
    run_until_idle(200);
    check("a5_rd_latency", 32'(first_rd_cyc - c0), 32'd1);
    check("a5_tx_fall", 32'(first_fall_cyc - c0), 32'd3);
    check("a5_done_cycle", 32'(done_cyc - c0), 32'(TOT));
    check("a5_nbits", 32'(bitlog.size()), 32'(NB));
`ifdef UART_TX_PARITY_EN
    check("a5_bits", 32'(packed_bits()), 32'h54A);
`else
    check("a5_bits", 32'(packed_bits()), 32'h34A);
`endif
    check("a5_pops", 32'(n_rd), 32'd1);
    check("a5_dones", 32'(n_done), 32'd1);
    check("a5_busy_end", 32'(busy), 32'd0);

    // Back-to-back 0x01, 0xFF
    clear_stats();
    push(8'h01);
    push(8'hFF);
    run_until_idle(300);
    check("b2b_pops", 32'(n_rd), 32'd2);
    check("b2b_dones", 32'(n_done), 32'd2);
    check("b2b_gap", 32'(last_gap), 32'd2);

    // Empty FIFO with tx_en high
    clear_stats();
    for (int i = 0; i < 100; i++) cycle();
    check("empty_pops", 32'(n_rd), 32'd0);
    check("empty_busy", 32'(busy), 32'd0);

    // Drop tx_en during data bit 3
    clear_stats();
    push(8'h11);
    push(8'h22);
    wait_offset(2 + 4 * CPB, 100);
    tx_en = 1'b0;
    run_until_idle(200);
    for (int i = 0; i < 10; i++) cycle();
    check("drop_pops", 32'(n_rd), 32'd1);
    check("drop_dones", 32'(n_done), 32'd1);
    check("drop_left", 32'(q.size()), 32'd1);

    // Reset during data bit 5, then a clean frame
    clear_stats();
    tx_en = 1'b1;
    wait_offset(2 + 6 * CPB, 100);
    rst = 1'b1;
    cycle();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("midrst_dones", 32'(n_done), 32'd0);
    rst = 1'b0;
    clear_stats();
    push(8'h3C);
    run_until_idle(200);
    check("post_rst_pops", 32'(n_rd), 32'd1);
    check("post_rst_dones", 32'(n_done), 32'd1);
    check("post_rst_nbits", 32'(bitlog.size()), 32'(NB));

`ifdef UART_TX_PARITY_EN
    clear_stats();
    push(8'h07);
    run_until_idle(200);
    check("par07_bits", 32'(packed_bits()), 32'h60E);
`endif

    // Randomized traffic, tx_en toggling and occasional resets
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0 && q.size() < 4) push(DW'($urandom));
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      cycle();
    end
    rst = 1'b0;
    tx_en = 1'b0;
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
